// File: rtl/drop_sequencer.sv
// Measure/decide/drop sequencer: averages four height sensors, derives a fall time
// from a bit-serial square root, and pulses the drop actuator when permitted.
module drop_sequencer #(
  parameter int DROP_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  sensor1,
  input  logic [7:0]  sensor2,
  input  logic [7:0]  sensor3,
  input  logic [7:0]  sensor4,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] t_act,
  output logic        drop_activated
);

  typedef enum logic [2:0] {IDLE, CAPTURE, SQRT, DECIDE, DROP} state_t;

  state_t      state;
  logic [7:0]  s1_q, s2_q, s3_q, s4_q;
  logic [15:0] radicand;
  logic [11:0] rem;
  logic [7:0]  root;
  logic [2:0]  iter;
  logic [7:0]  hold_cnt;

  logic [9:0]  sum;
  logic [7:0]  height;
  logic [11:0] rem_shift;
  logic [11:0] trial;
  logic        take;
  logic [7:0]  root_next;

  // One restoring-sqrt step: bring down the next radicand bit pair and try 4*root+1.
  always_comb begin
    sum       = {2'b00, s1_q} + {2'b00, s2_q} + {2'b00, s3_q} + {2'b00, s4_q};
    height    = sum[9:2];
    rem_shift = (rem << 2) | {10'd0, radicand[15:14]};
    trial     = {2'b00, root, 2'b01};
    take      = (rem_shift >= trial);
    root_next = {root[6:0], take};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      s4_q           <= '0;
      radicand       <= '0;
      rem            <= '0;
      root           <= '0;
      iter           <= '0;
      hold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      t_act          <= '0;
      drop_activated <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s1_q  <= sensor1;
            s2_q  <= sensor2;
            s3_q  <= sensor3;
            s4_q  <= sensor4;
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          radicand <= {height, 8'h00};
          rem      <= '0;
          root     <= '0;
          iter     <= '0;
          state    <= SQRT;
        end
        SQRT: begin
          rem      <= take ? (rem_shift - trial) : rem_shift;
          root     <= root_next;
          radicand <= {radicand[13:0], 2'b00};
          iter     <= iter + 3'd1;
          // Final step: publish the fall time straight from the completed root.
          if (iter == 3'd7) begin
            t_act <= {9'd0, root_next[7:1]};
            done  <= 1'b1;
            state <= DECIDE;
          end
        end
        DECIDE: begin
          if (drop_en && (t_act <= t_lim)) begin
            drop_activated <= 1'b1;
            hold_cnt       <= 8'(DROP_HOLD - 1);
            state          <= DROP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DROP: begin
          if (!drop_en || (hold_cnt == 8'd0)) begin
            drop_activated <= 1'b0;
            busy           <= 1'b0;
            hold_cnt       <= '0;
            state          <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          busy           <= 1'b0;
          drop_activated <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_sequencer.sv
// Bench for drop_sequencer: a timeline model checked every cycle, plus directed
// scenarios with hand-computed fall times, done timing and drop lengths.
module tb_drop_sequencer;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  sensor1, sensor2, sensor3, sensor4;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy;
  logic        done;
  logic [15:0] t_act;
  logic        drop_activated;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  drop_sequencer #(.DROP_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .t_lim(t_lim), .drop_en(drop_en), .busy(busy), .done(done),
    .t_act(t_act), .drop_activated(drop_activated)
  );

  always #5 clk = ~clk;

  // Fall time from the sensors: average height, scaled by 256, integer sqrt, halved.
  function automatic int ref_tact(input int a, input int b, input int c, input int d);
    int h, rad, r;
    h   = (a + b + c + d) / 4;
    rad = h * 256;
    r   = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
    return r / 2;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Timeline model: phase counts cycles since the accepted start edge.
  int          phase = 0;
  int          drop_left = 0;
  int          pend_tact = 0;
  bit          exp_busy = 0, exp_done = 0, exp_drop = 0;
  int          exp_tact = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0; exp_busy = 0; exp_done = 0; exp_drop = 0; exp_tact = 0;
    end else begin
      exp_done = 0;
      if (phase == 0) begin
        if (start) begin
          phase     = 1;
          exp_busy  = 1;
          pend_tact = ref_tact(sensor1, sensor2, sensor3, sensor4);
        end
      end else if (phase < 10) begin
        phase++;
        if (phase == 10) begin
          exp_done = 1;
          exp_tact = pend_tact;
        end
      end else if (phase == 10) begin
        if (drop_en && (exp_tact <= int'(t_lim))) begin
          exp_drop  = 1;
          drop_left = HOLD;
          phase     = 11;
        end else begin
          exp_busy = 0;
          phase    = 0;
        end
      end else begin
        drop_left--;
        if (!drop_en || drop_left == 0) begin
          exp_drop = 0;
          exp_busy = 0;
          phase    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_busy", int'(busy), int'(exp_busy));
      checkOutput("cyc_done", int'(done), int'(exp_done));
      checkOutput("cyc_drop", int'(drop_activated), int'(exp_drop));
      checkOutput("cyc_tact", int'(t_act), exp_tact);
    end
  end

  // Runs one sequence; pa/pb extra start pulses, dl/dh drop_en low/high, ra reset cycle.
  task automatic applyStimulus(
    input int a, input int b, input int c, input int d, input int tl, input bit den,
    input int pa, input int pb, input int dl, input int dh, input int ra,
    output int done_cyc, output int done_cnt, output int drop_cnt, output int busy_end);
    done_cyc = -1; done_cnt = 0; drop_cnt = 0; busy_end = -1;
    sensor1 = 8'(a); sensor2 = 8'(b); sensor3 = 8'(c); sensor4 = 8'(d);
    t_lim = 16'(tl); drop_en = den; start = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      start = (k == pa) || (k == pb);
      if (k == 3) begin
        sensor1 = 8'd255; sensor2 = 8'd255; sensor3 = 8'd255; sensor4 = 8'd255;
      end
      if (k == dl) drop_en = 1'b0;
      if (k == dh) drop_en = 1'b1;
      if (k == ra) rst_n = 1'b0;
      if (k == ra + 1) rst_n = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (drop_activated) drop_cnt++;
      if (!busy) begin
        busy_end = k;
        break;
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    if (busy_end < 0) checkOutput("timeout", busy_end, 0);
  endtask

  initial begin
    int dc, dn, dr, be;
    rst_n = 1'b0; start = 1'b0; drop_en = 1'b0; t_lim = '0;
    sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_drop", int'(drop_activated), 0);
    checkOutput("rst_tact", int'(t_act), 0);

    checkOutput("model_64", ref_tact(64, 64, 64, 64), 64);
    checkOutput("model_255", ref_tact(255, 255, 255, 255), 127);
    checkOutput("model_mix", ref_tact(10, 20, 30, 41), 40);

    $display("[TB] basic drop");
    applyStimulus(64, 64, 64, 64, 100, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s1_done_cyc", dc, 10);
    checkOutput("s1_done_cnt", dn, 1);
    checkOutput("s1_tact", int'(t_act), 64);
    checkOutput("s1_drop_len", dr, 8);
    checkOutput("s1_busy_end", be, 19);

    $display("[TB] over limit");
    applyStimulus(100, 100, 100, 100, 79, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s2_done_cyc", dc, 10);
    checkOutput("s2_tact", int'(t_act), 80);
    checkOutput("s2_drop_len", dr, 0);
    checkOutput("s2_busy_end", be, 11);

    $display("[TB] boundary heights");
    applyStimulus(255, 255, 255, 255, 200, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s3a_tact", int'(t_act), 127);
    checkOutput("s3a_drop_len", dr, 8);
    applyStimulus(10, 20, 30, 41, 40, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s3b_tact", int'(t_act), 40);
    checkOutput("s3b_drop_len", dr, 8);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s3c_tact", int'(t_act), 0);
    checkOutput("s3c_drop_len", dr, 8);

    $display("[TB] start ignored while busy");
    applyStimulus(64, 64, 64, 64, 100, 1, 5, 13, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s4_done_cnt", dn, 1);
    checkOutput("s4_tact", int'(t_act), 64);
    checkOutput("s4_busy_end", be, 19);
    applyStimulus(100, 100, 100, 100, 200, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s4b_done_cyc", dc, 10);
    checkOutput("s4b_tact", int'(t_act), 80);
    checkOutput("s4b_drop_len", dr, 8);

    $display("[TB] drop_en behaviour");
    applyStimulus(64, 64, 64, 64, 100, 1, 0, 0, 13, 0, 0, dc, dn, dr, be);
    checkOutput("s5a_drop_len", dr, 3);
    checkOutput("s5a_busy_end", be, 14);
    applyStimulus(100, 100, 100, 100, 200, 0, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s5b_done_cyc", dc, 10);
    checkOutput("s5b_tact", int'(t_act), 80);
    checkOutput("s5b_drop_len", dr, 0);
    checkOutput("s5b_busy_end", be, 11);
    applyStimulus(10, 20, 30, 41, 100, 1, 0, 0, 4, 7, 0, dc, dn, dr, be);
    checkOutput("s5c_tact", int'(t_act), 40);
    checkOutput("s5c_drop_len", dr, 8);

    $display("[TB] reset aborts");
    applyStimulus(64, 64, 64, 64, 100, 1, 0, 0, 0, 0, 5, dc, dn, dr, be);
    checkOutput("s6a_done_cnt", dn, 0);
    checkOutput("s6a_busy_end", be, 6);
    checkOutput("s6a_tact", int'(t_act), 0);
    applyStimulus(100, 100, 100, 100, 200, 1, 0, 0, 0, 0, 12, dc, dn, dr, be);
    checkOutput("s6b_done_cnt", dn, 1);
    checkOutput("s6b_drop_len", dr, 2);
    checkOutput("s6b_busy_end", be, 13);
    checkOutput("s6b_tact", int'(t_act), 0);
    applyStimulus(10, 20, 30, 41, 100, 1, 0, 0, 0, 0, 0, dc, dn, dr, be);
    checkOutput("s6c_done_cyc", dc, 10);
    checkOutput("s6c_tact", int'(t_act), 40);
    checkOutput("s6c_drop_len", dr, 8);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
